// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if: fetch, register-file, forwarding and EX-side signals of the decode stage.
// The master side is the surrounding pipeline; the decode stage connects as slave.
interface id_operand_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  fs_valid;
    logic [DATA_WIDTH-1:0] fs_inst;
    logic [DATA_WIDTH-1:0] fs_pc;
    logic                  ds_allowin;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic                  es_fwd_wen;
    logic                  es_fwd_load;
    logic [ADDR_WIDTH-1:0] es_fwd_waddr;
    logic [DATA_WIDTH-1:0] es_fwd_wdata;
    logic                  ms_fwd_wen;
    logic [ADDR_WIDTH-1:0] ms_fwd_waddr;
    logic [DATA_WIDTH-1:0] ms_fwd_wdata;
    logic                  ws_fwd_wen;
    logic [ADDR_WIDTH-1:0] ws_fwd_waddr;
    logic [DATA_WIDTH-1:0] ws_fwd_wdata;
    logic                  es_allowin;
    logic                  ds_to_es_valid;
    logic [DATA_WIDTH-1:0] ds_to_es_pc;
    logic [DATA_WIDTH-1:0] ds_to_es_inst;
    logic [DATA_WIDTH-1:0] ds_to_es_src1;
    logic [DATA_WIDTH-1:0] ds_to_es_src2;

    modport master (
        output fs_valid, fs_inst, fs_pc, flush, rdata1, rdata2,
               es_fwd_wen, es_fwd_load, es_fwd_waddr, es_fwd_wdata,
               ms_fwd_wen, ms_fwd_waddr, ms_fwd_wdata,
               ws_fwd_wen, ws_fwd_waddr, ws_fwd_wdata, es_allowin,
        input  ds_allowin, raddr1, raddr2,
               ds_to_es_valid, ds_to_es_pc, ds_to_es_inst, ds_to_es_src1, ds_to_es_src2
    );

    modport slave (
        input  fs_valid, fs_inst, fs_pc, flush, rdata1, rdata2,
               es_fwd_wen, es_fwd_load, es_fwd_waddr, es_fwd_wdata,
               ms_fwd_wen, ms_fwd_waddr, ms_fwd_wdata,
               ws_fwd_wen, ws_fwd_waddr, ws_fwd_wdata, es_allowin,
        output ds_allowin, raddr1, raddr2,
               ds_to_es_valid, ds_to_es_pc, ds_to_es_inst, ds_to_es_src1, ds_to_es_src2
    );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage: IF/ID register, operand fetch with EX/MEM/WB forwarding,
// load-use stall and ID/EX register under a valid/allowin handshake.
module id_operand_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input logic clk,
    input logic rstn,
    id_operand_stage_if.slave bus
);
    logic                  ds_valid;
    logic [DATA_WIDTH-1:0] ds_pc;
    logic [DATA_WIDTH-1:0] ds_inst;
    logic                  es_valid;
    logic [DATA_WIDTH-1:0] es_pc;
    logic [DATA_WIDTH-1:0] es_inst;
    logic [DATA_WIDTH-1:0] es_src1;
    logic [DATA_WIDTH-1:0] es_src2;
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] rf   [2];
    logic [DATA_WIDTH-1:0] src  [2];
    logic                  haz  [2];
    logic                  stall;
    logic                  ds_ready_go;
    logic                  id_ex_allowin;
    logic                  ds_allowin;
    logic                  to_es_go;

    assign addr[0] = ADDR_WIDTH'(ds_inst[25:21]);
    assign addr[1] = ADDR_WIDTH'(ds_inst[20:16]);
    assign rf[0]   = bus.rdata1;
    assign rf[1]   = bus.rdata2;

    // Youngest producer wins; an EX load cannot supply data yet, so it raises a hazard instead.
    for (genvar i = 0; i < 2; i++) begin : g_src
        assign {haz[i], src[i]} =
            (addr[i] == '0)                                     ? '0 :
            (bus.es_fwd_wen && bus.es_fwd_waddr == addr[i])     ? {bus.es_fwd_load, bus.es_fwd_wdata} :
            (bus.ms_fwd_wen && bus.ms_fwd_waddr == addr[i])     ? {1'b0, bus.ms_fwd_wdata} :
            (bus.ws_fwd_wen && bus.ws_fwd_waddr == addr[i])     ? {1'b0, bus.ws_fwd_wdata} :
                                                                  {1'b0, rf[i]};
    end

    assign stall         = ds_valid && (haz[0] || haz[1]);
    assign ds_ready_go   = !stall;
    assign id_ex_allowin = !es_valid || bus.es_allowin;
    assign ds_allowin    = !ds_valid || (ds_ready_go && id_ex_allowin);
    assign to_es_go      = ds_valid && ds_ready_go;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ds_valid <= 1'b0;
            ds_pc    <= '0;
            ds_inst  <= '0;
        end else if (bus.flush) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= bus.fs_valid;
            if (bus.fs_valid) begin
                ds_pc   <= bus.fs_pc;
                ds_inst <= bus.fs_inst;
            end
        end
    end

    // A stalled instruction leaves a bubble here while IF/ID keeps holding it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            es_valid <= 1'b0;
            es_pc    <= '0;
            es_inst  <= '0;
            es_src1  <= '0;
            es_src2  <= '0;
        end else if (bus.flush) begin
            es_valid <= 1'b0;
        end else if (id_ex_allowin) begin
            es_valid <= to_es_go;
            if (to_es_go) begin
                es_pc   <= ds_pc;
                es_inst <= ds_inst;
                es_src1 <= src[0];
                es_src2 <= src[1];
            end
        end
    end

    assign bus.ds_allowin     = ds_allowin;
    assign bus.raddr1         = addr[0];
    assign bus.raddr2         = addr[1];
    assign bus.ds_to_es_valid = es_valid;
    assign bus.ds_to_es_pc    = es_pc;
    assign bus.ds_to_es_inst  = es_inst;
    assign bus.ds_to_es_src1  = es_src1;
    assign bus.ds_to_es_src2  = es_src2;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed plan scenarios plus randomized traffic, each cycle
// compared against a transaction-level model of the two pipeline slots.
module tb_id_operand_stage;
    localparam int DW = 32;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    id_operand_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    id_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct {
        bit          v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] s1;
        logic [31:0] s2;
    } slot_t;

    slot_t ifid, idex;
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addu(input int rd, input int rs, input int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h21};
    endfunction

    function automatic logic [31:0] lw(input int rt, input int rs);
        return {6'h23, 5'(rs), 5'(rt), 16'd0};
    endfunction

    // Register value as seen by a consumer: scan producers youngest-first.
    function automatic logic [31:0] operand(input logic [5:0] a, input logic [31:0] rfv, output bit haz);
        logic        w  [3];
        logic [5:0]  wa [3];
        logic [31:0] wd [3];
        w  = '{bus.es_fwd_wen, bus.ms_fwd_wen, bus.ws_fwd_wen};
        wa = '{bus.es_fwd_waddr, bus.ms_fwd_waddr, bus.ws_fwd_waddr};
        wd = '{bus.es_fwd_wdata, bus.ms_fwd_wdata, bus.ws_fwd_wdata};
        haz = 1'b0;
        if (a == 6'd0) return 32'd0;
        for (int k = 0; k < 3; k++)
            if (w[k] && wa[k] == a) begin
                haz = (k == 0) && bus.es_fwd_load;
                return wd[k];
            end
        return rfv;
    endfunction

    task automatic idle();
        bus.fs_valid = 1'b0; bus.fs_inst = '0; bus.fs_pc = '0; bus.flush = 1'b0;
        bus.rdata1 = '0; bus.rdata2 = '0; bus.es_allowin = 1'b1;
        bus.es_fwd_wen = 1'b0; bus.es_fwd_load = 1'b0; bus.es_fwd_waddr = '0; bus.es_fwd_wdata = '0;
        bus.ms_fwd_wen = 1'b0; bus.ms_fwd_waddr = '0; bus.ms_fwd_wdata = '0;
        bus.ws_fwd_wen = 1'b0; bus.ws_fwd_waddr = '0; bus.ws_fwd_wdata = '0;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
        bus.fs_valid = 1'b1; bus.fs_inst = inst; bus.fs_pc = pc;
    endtask

    // Inputs are already applied; check combinational outputs, advance the model, check registers.
    task automatic step();
        logic [5:0]  a1, a2;
        logic [31:0] o1, o2;
        bit h1, h2, blocked, ex_free, take;
        #1;
        a1 = {1'b0, ifid.inst[25:21]};
        a2 = {1'b0, ifid.inst[20:16]};
        chk("raddr1", 32'(bus.raddr1), 32'(a1));
        chk("raddr2", 32'(bus.raddr2), 32'(a2));
        o1 = operand(a1, bus.rdata1, h1);
        o2 = operand(a2, bus.rdata2, h2);
        blocked = ifid.v && (h1 || h2);
        ex_free = !idex.v || bus.es_allowin;
        take = !ifid.v || (!blocked && ex_free);
        chk("ds_allowin", 32'(bus.ds_allowin), 32'(take));
        if (!rstn) begin
            ifid = '{default: 0};
            idex = '{default: 0};
        end else if (bus.flush) begin
            ifid.v = 1'b0;
            idex.v = 1'b0;
        end else begin
            if (ex_free) begin
                if (ifid.v && !blocked) idex = '{v: 1'b1, pc: ifid.pc, inst: ifid.inst, s1: o1, s2: o2};
                else idex.v = 1'b0;
            end
            if (take) begin
                if (bus.fs_valid) ifid = '{v: 1'b1, pc: bus.fs_pc, inst: bus.fs_inst, s1: 0, s2: 0};
                else ifid.v = 1'b0;
            end
        end
        @(negedge clk);
        chk("to_es_valid", 32'(bus.ds_to_es_valid), 32'(idex.v));
        chk("to_es_pc", bus.ds_to_es_pc, idex.pc);
        chk("to_es_inst", bus.ds_to_es_inst, idex.inst);
        chk("to_es_src1", bus.ds_to_es_src1, idex.s1);
        chk("to_es_src2", bus.ds_to_es_src2, idex.s2);
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        ifid = '{default: 0};
        idex = '{default: 0};

        // reset held with a valid fetch, then release
        fetch(addu(1, 2, 3), 32'h100);
        step(); step();
        chk("rst_hold_valid", 32'(bus.ds_to_es_valid), 32'd0);
        rstn = 1'b1;
        step();
        idle();
        step();
        chk("rst_first_valid", 32'(bus.ds_to_es_valid), 32'd1);
        chk("rst_first_pc", bus.ds_to_es_pc, 32'h100);

        // EX forwarding to both sources of a dependent addu
        idle(); fetch(addu(3, 1, 2), 32'h200); step();
        fetch(addu(4, 3, 3), 32'h204); step();
        idle();
        bus.es_fwd_wen = 1'b1; bus.es_fwd_waddr = 6'd3; bus.es_fwd_wdata = 32'h55;
        bus.rdata1 = 32'hAAAA; bus.rdata2 = 32'hAAAA;
        step();
        chk("exfwd_valid", 32'(bus.ds_to_es_valid), 32'd1);
        chk("exfwd_src1", bus.ds_to_es_src1, 32'h55);
        chk("exfwd_src2", bus.ds_to_es_src2, 32'h55);

        // load-use: one bubble, then MEM forwarding
        idle(); fetch(lw(5, 0), 32'h300); step();
        fetch(addu(6, 5, 0), 32'h304); step();
        idle();
        bus.es_fwd_wen = 1'b1; bus.es_fwd_load = 1'b1; bus.es_fwd_waddr = 6'd5; bus.es_fwd_wdata = 32'h1111;
        bus.rdata1 = 32'hBAD0BAD0;
        step();
        chk("lu_bubble", 32'(bus.ds_to_es_valid), 32'd0);
        idle();
        bus.ms_fwd_wen = 1'b1; bus.ms_fwd_waddr = 6'd5; bus.ms_fwd_wdata = 32'hDEADBEEF;
        bus.rdata1 = 32'hBAD0BAD0;
        step();
        chk("lu_valid", 32'(bus.ds_to_es_valid), 32'd1);
        chk("lu_pc", bus.ds_to_es_pc, 32'h304);
        chk("lu_src1", bus.ds_to_es_src1, 32'hDEADBEEF);

        // WB write-through, and $0 never forwarded
        idle(); fetch(addu(8, 7, 0), 32'h400); step();
        idle();
        bus.ws_fwd_wen = 1'b1; bus.ws_fwd_waddr = 6'd7; bus.ws_fwd_wdata = 32'h12345678;
        fetch(addu(8, 0, 0), 32'h404);
        step();
        chk("wb_src1", bus.ds_to_es_src1, 32'h12345678);
        idle();
        bus.ws_fwd_wen = 1'b1; bus.ws_fwd_waddr = 6'd0; bus.ws_fwd_wdata = 32'h12345678;
        bus.rdata1 = 32'hFFFFFFFF;
        step();
        chk("zero_valid", 32'(bus.ds_to_es_valid), 32'd1);
        chk("zero_src1", bus.ds_to_es_src1, 32'd0);

        // backpressure with a full pipe
        idle(); fetch(addu(9, 10, 11), 32'h500); step();
        fetch(addu(10, 11, 12), 32'h504); step();
        fetch(addu(11, 12, 13), 32'h508); step();
        fetch(addu(12, 13, 14), 32'h50C);
        bus.es_allowin = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("bp_allowin", 32'(bus.ds_allowin), 32'd0);
            chk("bp_pc", bus.ds_to_es_pc, 32'h504);
        end
        bus.es_allowin = 1'b1;
        step();
        chk("bp_next_pc", bus.ds_to_es_pc, 32'h508);
        idle(); step();
        chk("bp_last_pc", bus.ds_to_es_pc, 32'h50C);
        step();
        chk("bp_drained", 32'(bus.ds_to_es_valid), 32'd0);

        // flush during a load-use stall
        idle(); fetch(lw(5, 0), 32'h600); step();
        fetch(addu(6, 5, 5), 32'h604); step();
        idle();
        bus.es_fwd_wen = 1'b1; bus.es_fwd_load = 1'b1; bus.es_fwd_waddr = 6'd5;
        bus.flush = 1'b1;
        step();
        chk("fl_valid", 32'(bus.ds_to_es_valid), 32'd0);
        idle(); fetch(addu(2, 1, 1), 32'h608);
        #1;
        chk("fl_allowin", 32'(bus.ds_allowin), 32'd1);
        step();
        idle(); step();
        chk("fl_next_valid", 32'(bus.ds_to_es_valid), 32'd1);
        chk("fl_next_pc", bus.ds_to_es_pc, 32'h608);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rstn = ($urandom_range(0, 49) != 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            bus.fs_valid = 1'($urandom_range(0, 1));
            bus.fs_inst = $urandom;
            bus.fs_inst[25:21] = 5'($urandom_range(0, 7));
            bus.fs_inst[20:16] = 5'($urandom_range(0, 7));
            bus.fs_pc = $urandom;
            bus.rdata1 = $urandom; bus.rdata2 = $urandom;
            bus.es_allowin = ($urandom_range(0, 3) != 0);
            bus.es_fwd_wen = 1'($urandom_range(0, 1)); bus.es_fwd_load = ($urandom_range(0, 2) == 0);
            bus.es_fwd_waddr = 6'($urandom_range(0, 7)); bus.es_fwd_wdata = $urandom;
            bus.ms_fwd_wen = 1'($urandom_range(0, 1));
            bus.ms_fwd_waddr = 6'($urandom_range(0, 7)); bus.ms_fwd_wdata = $urandom;
            bus.ws_fwd_wen = 1'($urandom_range(0, 1));
            bus.ws_fwd_waddr = 6'($urandom_range(0, 7)); bus.ws_fwd_wdata = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
Decode/operand-fetch stage of the 5-stage CPU. It sits directly upstream of the EX stage and drives the read ports of the register file. It holds the IF/ID pipeline register, extracts rs/rt, and reads both operands. It resolves EX/MEM/WB forwarding and load-use stalls, then delivers operands to the ID/EX pipeline register under a valid/allowin handshake.

Parameters:
DATA_WIDTH, 32, operand/instruction/PC width
ADDR_WIDTH, 6, register-file address width; the 5-bit rs/rt fields are zero-extended to it

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  synchronous active-low reset, sampled on rising edge of clk
fs_valid  input  1  fetch stage presents an instruction
fs_inst  input  DATA_WIDTH  fetched instruction
fs_pc  input  DATA_WIDTH  PC of fetched instruction
ds_allowin  output  1  this stage accepts fs_* this cycle
flush  input  1  branch/exception redirect; kill younger instructions
raddr1  output  ADDR_WIDTH  register-file read address 1 = {0, inst[25:21]}
raddr2  output  ADDR_WIDTH  register-file read address 2 = {0, inst[20:16]}
rdata1  input  DATA_WIDTH  register-file read data 1 (combinational)
rdata2  input  DATA_WIDTH  register-file read data 2 (combinational)
es_fwd_wen  input  1  EX-stage instruction valid and writes a register
es_fwd_load  input  1  EX-stage instruction is a load (result not yet available)
es_fwd_waddr  input  ADDR_WIDTH  EX destination
es_fwd_wdata  input  DATA_WIDTH  EX result
ms_fwd_wen  input  1  MEM-stage instruction valid and writes a register
ms_fwd_waddr  input  ADDR_WIDTH  MEM destination
ms_fwd_wdata  input  DATA_WIDTH  MEM result (load data included)
ws_fwd_wen  input  1  WB write enable (same signal that drives the regfile wen)
ws_fwd_waddr  input  ADDR_WIDTH  WB destination
ws_fwd_wdata  input  DATA_WIDTH  WB data
es_allowin  input  1  EX stage accepts ID/EX register this cycle
ds_to_es_valid  output  1  ID/EX register holds a valid instruction
ds_to_es_pc  output  DATA_WIDTH  registered PC
ds_to_es_inst  output  DATA_WIDTH  registered instruction
ds_to_es_src1  output  DATA_WIDTH  registered resolved operand 1
ds_to_es_src2  output  DATA_WIDTH  registered resolved operand 2

Behaviour:
- Two register stages: IF/ID (ds_valid, ds_pc, ds_inst) and ID/EX (ds_to_es_*). Total latency fetch->ds_to_es_valid is 2 cycles with no stall.
- Reset (rstn=0 at edge): ds_valid=0, ds_to_es_valid=0, all pc/inst/src registers=0. Reset mid-stall discards all in-flight instructions.
- Operand resolution per source (combinational from ds_inst), first match wins:
  - addr==0 -> 0
  - es_fwd_wen && es_fwd_waddr==addr -> es_fwd_wdata, or hazard if es_fwd_load
  - ms_fwd_wen && match -> ms_fwd_wdata
  - ws_fwd_wen && match -> ws_fwd_wdata
  - otherwise -> rdata
- stall = ds_valid && (load hazard on src1 or src2). Both sources are checked regardless of opcode.
- ds_ready_go = !stall. ID/EX allowin (id_ex_allowin) = !ds_to_es_valid || es_allowin.
- ds_allowin = !ds_valid || (ds_ready_go && id_ex_allowin).
- IF/ID update:
  - if flush: ds_valid<=0
  - else if ds_allowin: ds_valid<=fs_valid, and pc/inst load when fs_valid
- ID/EX update:
  - if flush: ds_to_es_valid<=0
  - else if id_ex_allowin: ds_to_es_valid<=ds_valid && ds_ready_go, and src/pc/inst load when that term is 1
- Bubble: during a stall the ID/EX register takes valid=0 while IF/ID holds its value; no operand is captured stale.
- flush has priority over all loads in the same cycle and affects only these two registers.
- WB write and ID read of the same register in the same cycle: the forwarded ws_fwd_wdata is used, never the old regfile value.
- Backpressure: when es_allowin=0 and ds_to_es_valid=1, all ds_to_es_* hold bit-stable.

Test Plan:
- Reset with fs_valid=1 held -> ds_to_es_valid=0 while rstn=0; first instruction appears 2 cycles after release.
- addu $3,$1,$2 then addu $4,$3,$3 back-to-back, EX result 0x00000055 -> second instr src1=src2=0x00000055, no stall.
- lw $5 followed immediately by addu $6,$5,$0 -> exactly one bubble (ds_to_es_valid=0 for 1 cycle), then src1=MEM load data 0xDEADBEEF.
- ws_fwd_wen=1 with ws_fwd_waddr=7, ws_fwd_wdata=0x12345678, and rdata1 still old 0 while ID reads $7 -> src1=0x12345678. Same test with waddr=0 and rs=0 -> src1=0.
- es_allowin=0 for 3 cycles with a full pipe -> ds_to_es_* stable, ds_allowin=0, no instruction lost or duplicated.
- flush asserted while stalled on a load-use -> both valids 0 next cycle, and the next fetched instruction flows normally.
